// File: rtl/fetch_pc_sp_unit_if.sv
// Bundle between the fetch/stack-pointer stage and the control unit and memories.
// The control side drives strobes and the fetched word; the fetch unit returns PC, IR and stack state.
interface fetch_pc_sp_unit_if #(
    parameter int PC_WIDTH = 16,
    parameter int SP_WIDTH = 9
);
    logic [15:0]         imemData;
    logic                instRegWrite;
    logic                pcWrite;
    logic                pcSelect;
    logic [15:0]         jumpAddr;
    logic                spWrite;
    logic                spSelect;
    logic [PC_WIDTH-1:0] imemAddr;
    logic [15:0]         cuInput;
    logic [SP_WIDTH-1:0] sP;
    logic [PC_WIDTH-1:0] stackAddr;
    logic                spOverflow;
    logic                spUnderflow;

    modport master (
        output imemData, instRegWrite, pcWrite, pcSelect, jumpAddr, spWrite, spSelect,
        input  imemAddr, cuInput, sP, stackAddr, spOverflow, spUnderflow
    );

    modport slave (
        input  imemData, instRegWrite, pcWrite, pcSelect, jumpAddr, spWrite, spSelect,
        output imemAddr, cuInput, sP, stackAddr, spOverflow, spUnderflow
    );
endinterface

// File: rtl/fetch_pc_sp_unit.sv
// Fetch and stack-pointer stage: holds PC, instruction register and stack pointer,
// updated only by the control unit's instRegWrite / pcWrite / spWrite strobes.
module fetch_pc_sp_unit #(
    parameter int                  PC_WIDTH   = 16,
    parameter int                  SP_WIDTH   = 9,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [PC_WIDTH-1:0] STACK_BASE = '0
) (
    input logic               clk,
    input logic               reset,
    fetch_pc_sp_unit_if.slave bus
);
    localparam logic [SP_WIDTH-1:0] SP_MAX = '1;

    logic [PC_WIDTH-1:0] pc_p0;
    logic [15:0]         ir_p0;
    logic [SP_WIDTH-1:0] sp_p0;
    logic                spOverflow_p0;
    logic                spUnderflow_p0;
    logic                spFull;
    logic                spEmpty;

    // Push addresses the free slot at sP; pop addresses the top entry at sP-1, clamped at empty.
    function automatic logic [PC_WIDTH-1:0] calcStackAddr(
        input logic [SP_WIDTH-1:0] sp,
        input logic                push
    );
        logic [PC_WIDTH-1:0] offset;
        offset = PC_WIDTH'(sp);
        if (!push && (sp != '0))
            offset = offset - PC_WIDTH'(1);
        return STACK_BASE + offset;
    endfunction

    assign spFull  = (sp_p0 == SP_MAX);
    assign spEmpty = (sp_p0 == '0);

    // Stage p0: architectural state, every bit cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_p0          <= RESET_PC;
            ir_p0          <= '0;
            sp_p0          <= '0;
            spOverflow_p0  <= 1'b0;
            spUnderflow_p0 <= 1'b0;
        end else begin
            if (bus.instRegWrite)
                ir_p0 <= bus.imemData;
            if (bus.pcWrite)
                pc_p0 <= bus.pcSelect ? PC_WIDTH'(bus.jumpAddr) : pc_p0 + PC_WIDTH'(1);
            if (bus.spWrite) begin
                if (bus.spSelect) begin
                    if (spFull)
                        spOverflow_p0 <= 1'b1;
                    else
                        sp_p0 <= sp_p0 + SP_WIDTH'(1);
                end else begin
                    if (spEmpty)
                        spUnderflow_p0 <= 1'b1;
                    else
                        sp_p0 <= sp_p0 - SP_WIDTH'(1);
                end
            end
        end
    end

    assign bus.imemAddr    = pc_p0;
    assign bus.cuInput     = ir_p0;
    assign bus.sP          = sp_p0;
    assign bus.stackAddr   = calcStackAddr(sp_p0, bus.spSelect);
    assign bus.spOverflow  = spOverflow_p0;
    assign bus.spUnderflow = spUnderflow_p0;
endmodule

// File: tb/tb_fetch_pc_sp_unit.sv
// Scoreboard bench for fetch_pc_sp_unit: stimulus queues hand-computed expected state,
// a negedge monitor pops and compares against the DUT outputs.
module tb_fetch_pc_sp_unit;
    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [15:0] ir;
        logic [8:0]  sp;
        logic [15:0] stk;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    fetch_pc_sp_unit_if bus ();

    fetch_pc_sp_unit #(.STACK_BASE(16'h0100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string n, input string f, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
        end
    endtask

    task automatic expectState(input string n, input logic [15:0] pc, input logic [15:0] ir,
                               input logic [8:0] sp, input logic [15:0] stk,
                               input logic ovf, input logic unf);
        exp_t e;
        e.name = n; e.pc = pc; e.ir = ir; e.sp = sp; e.stk = stk; e.ovf = ovf; e.unf = unf;
        sbq.push_back(e);
    endtask

    // One clock of stimulus; when chk is set the post-edge state is queued for the monitor.
    task automatic cyc(input logic irw, input logic pcw, input logic psel, input logic [15:0] jaddr,
                       input logic spw, input logic ssel, input logic [15:0] imem, input bit chk,
                       input string n, input logic [15:0] pc, input logic [15:0] ir,
                       input logic [8:0] sp, input logic [15:0] stk, input logic ovf, input logic unf);
        bus.instRegWrite = irw;
        bus.pcWrite      = pcw;
        bus.pcSelect     = psel;
        bus.jumpAddr     = jaddr;
        bus.spWrite      = spw;
        bus.spSelect     = ssel;
        bus.imemData     = imem;
        @(posedge clk);
        if (chk) expectState(n, pc, ir, sp, stk, ovf, unf);
        @(negedge clk);
        #1;
    endtask

    // Reset asserted mid-cycle; the monitor checks before the next rising edge.
    task automatic midReset(input string n);
        bus.instRegWrite = 1'b0;
        bus.pcWrite      = 1'b0;
        bus.spWrite      = 1'b0;
        bus.spSelect     = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        expectState(n, 16'h0000, 16'h0000, 9'h000, 16'h0100, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                cmp(e.name, "imemAddr", bus.imemAddr, e.pc);
                cmp(e.name, "cuInput", bus.cuInput, e.ir);
                cmp(e.name, "sP", {7'b0, bus.sP}, {7'b0, e.sp});
                cmp(e.name, "stackAddr", bus.stackAddr, e.stk);
                cmp(e.name, "spOverflow", {15'b0, bus.spOverflow}, {15'b0, e.ovf});
                cmp(e.name, "spUnderflow", {15'b0, bus.spUnderflow}, {15'b0, e.unf});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.instRegWrite = 1'b0;
        bus.pcWrite      = 1'b0;
        bus.pcSelect     = 1'b0;
        bus.jumpAddr     = 16'h0000;
        bus.spWrite      = 1'b0;
        bus.spSelect     = 1'b0;
        bus.imemData     = 16'h0000;
        reset            = 1'b1;
        @(posedge clk);
        #1;
        expectState("rst0", 16'h0000, 16'h0000, 9'h000, 16'h0100, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Build PC=0x0042, SP=5, IR=0x7777 then reset mid-run
        cyc(0, 1, 1, 16'h0042, 0, 0, 16'h0000, 1, "jump42", 16'h0042, 16'h0000, 9'h000, 16'h0100, 0, 0);
        for (int i = 1; i <= 5; i++)
            cyc(0, 0, 0, 16'h0000, 1, 1, 16'h0000, (i == 5), "push5",
                16'h0042, 16'h0000, 9'h005, 16'h0105, 0, 0);
        cyc(1, 0, 0, 16'h0000, 0, 0, 16'h7777, 1, "ir7777", 16'h0042, 16'h7777, 9'h005, 16'h0104, 0, 0);
        midReset("rstMid");

        // Fetch / PC update
        cyc(1, 0, 0, 16'h0000, 0, 0, 16'h6A25, 1, "irLoad",   16'h0000, 16'h6A25, 9'h000, 16'h0100, 0, 0);
        cyc(0, 1, 0, 16'h0000, 0, 0, 16'h1234, 1, "pcInc",    16'h0001, 16'h6A25, 9'h000, 16'h0100, 0, 0);
        cyc(0, 1, 1, 16'h1ABC, 0, 0, 16'h1234, 1, "jump",     16'h1ABC, 16'h6A25, 9'h000, 16'h0100, 0, 0);
        cyc(0, 1, 1, 16'hFFFF, 0, 0, 16'h1234, 1, "jumpFFFF", 16'hFFFF, 16'h6A25, 9'h000, 16'h0100, 0, 0);
        cyc(0, 1, 0, 16'h0000, 0, 0, 16'h1234, 1, "wrap",     16'h0000, 16'h6A25, 9'h000, 16'h0100, 0, 0);
        cyc(1, 1, 0, 16'h0000, 0, 0, 16'hBEEF, 1, "irPcBoth", 16'h0001, 16'hBEEF, 9'h000, 16'h0100, 0, 0);
        cyc(0, 0, 1, 16'h0ABC, 0, 0, 16'h4321, 1, "pcHold",   16'h0001, 16'hBEEF, 9'h000, 16'h0100, 0, 0);

        // Stack push/pop and address generation
        cyc(0, 0, 0, 16'h0000, 1, 1, 16'h0000, 1, "push1", 16'h0001, 16'hBEEF, 9'h001, 16'h0101, 0, 0);
        cyc(0, 0, 0, 16'h0000, 1, 1, 16'h0000, 1, "push2", 16'h0001, 16'hBEEF, 9'h002, 16'h0102, 0, 0);
        cyc(0, 0, 0, 16'h0000, 1, 1, 16'h0000, 1, "push3", 16'h0001, 16'hBEEF, 9'h003, 16'h0103, 0, 0);
        cyc(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, "pop1",  16'h0001, 16'hBEEF, 9'h002, 16'h0101, 0, 0);
        cyc(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, "pop2",  16'h0001, 16'hBEEF, 9'h001, 16'h0100, 0, 0);
        cyc(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, "pop3",  16'h0001, 16'hBEEF, 9'h000, 16'h0100, 0, 0);
        cyc(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, "popUnder",  16'h0001, 16'hBEEF, 9'h000, 16'h0100, 0, 1);
        cyc(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, "unfSticky", 16'h0001, 16'hBEEF, 9'h000, 16'h0100, 0, 1);
        cyc(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, "spHold",    16'h0001, 16'hBEEF, 9'h000, 16'h0100, 0, 1);

        for (int i = 1; i <= 511; i++)
            cyc(0, 0, 0, 16'h0000, 1, 1, 16'h0000, (i == 511), "pushFull",
                16'h0001, 16'hBEEF, 9'h1FF, 16'h02FF, 0, 1);
        cyc(0, 0, 0, 16'h0000, 1, 1, 16'h0000, 1, "pushOver",    16'h0001, 16'hBEEF, 9'h1FF, 16'h02FF, 1, 1);
        cyc(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, "popAfterOvf", 16'h0001, 16'hBEEF, 9'h1FE, 16'h02FD, 1, 1);

        // IR holds while imemData toggles
        cyc(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, "irHold0", 16'h0001, 16'hBEEF, 9'h1FE, 16'h02FD, 1, 1);
        cyc(0, 0, 0, 16'h0000, 0, 0, 16'hFFFF, 1, "irHold1", 16'h0001, 16'hBEEF, 9'h1FE, 16'h02FD, 1, 1);
        cyc(0, 0, 0, 16'h0000, 0, 0, 16'h5555, 1, "irHold2", 16'h0001, 16'hBEEF, 9'h1FE, 16'h02FD, 1, 1);
        cyc(0, 0, 0, 16'h0000, 0, 0, 16'hAAAA, 1, "irHold3", 16'h0001, 16'hBEEF, 9'h1FE, 16'h02FD, 1, 1);

        // Reset clears sticky flags; first update lands on the first edge after release
        midReset("rstFlags");
        cyc(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, "postRst", 16'h0001, 16'h0000, 9'h000, 16'h0100, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
